// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator: drives a probe into an external magnitude comparator and
// narrows [lo, hi] from its gt/eq/lt answers until the hidden target is found.
module cmp_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] PROBE_INIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] PROBE_MAX  = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    CMP_LIMIT  = CW'(WIDTH + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             error_q, error_d;
    logic             done_q, done_d;

    logic             hit, fail;
    logic [WIDTH:0]   lo_upd, hi_upd;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q     <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            probe_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            found_q  <= found_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        probe_d  = probe_q;
        result_d = result_q;
        found_d  = found_q;
        error_d  = error_q;
        done_d   = 1'b0;
        hit      = 1'b0;
        fail     = 1'b0;
        lo_upd   = lo_q;
        hi_upd   = hi_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = HI_INIT;
                    cnt_d   = '0;
                    probe_d = PROBE_INIT;
                    found_d = 1'b0;
                    error_d = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                cnt_d = cnt_q + CW'(1);
                if (!$onehot({cmp_gt, cmp_eq, cmp_lt})) begin
                    fail = 1'b1;
                end else if (cmp_eq) begin
                    hit = 1'b1;
                end else if (cmp_gt) begin
                    if (probe_q == '0) fail = 1'b1;
                    else hi_upd = {1'b0, probe_q} - (WIDTH+1)'(1);
                end else begin
                    if (probe_q == PROBE_MAX) fail = 1'b1;
                    else lo_upd = {1'b0, probe_q} + (WIDTH+1)'(1);
                end

                // Probe is left unchanged when the narrowed window proves inconsistent.
                if (!fail && !hit) begin
                    if (lo_upd > hi_upd || cnt_d == CMP_LIMIT) begin
                        fail = 1'b1;
                    end else begin
                        lo_d    = lo_upd;
                        hi_d    = hi_upd;
                        probe_d = WIDTH'(({1'b0, lo_upd} + {1'b0, hi_upd}) >> 1);
                    end
                end

                if (hit) begin
                    found_d  = 1'b1;
                    result_d = probe_q;
                    error_d  = 1'b0;
                end else if (fail) begin
                    found_d = 1'b0;
                    error_d = 1'b1;
                end
                if (hit || fail) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == SEARCH);
        done   = done_q;
        probe  = probe_q;
        found  = found_q;
        result = result_q;
        error  = error_q;
    end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl at WIDTH=4 with a behavioural comparator model.
module tb_cmp_search_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cmp_gt, cmp_eq, cmp_lt;
    logic [W-1:0] probe, result;
    logic         busy, done, found, error;

    logic [W-1:0] target = '0;
    logic         mode_lt = 1'b0;
    logic         bad = 1'b0;
    int           noise_cycles = 0;

    logic [W-1:0] seen [16];
    int           nseen;
    int           errors = 0;
    int           checks = 0;

    cmp_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .error  (error)
    );

    always #5 clk = ~clk;

    always_comb begin
        cmp_gt = (probe > target);
        cmp_eq = (probe == target);
        cmp_lt = (probe < target);
        if (mode_lt) {cmp_gt, cmp_eq, cmp_lt} = 3'b001;
        if (bad)     {cmp_gt, cmp_eq, cmp_lt} = 3'b101;
    end

    task automatic start_search(input logic [W-1:0] tgt);
        @(negedge clk);
        target = tgt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int ncmp);
        bit to;
        ncmp  = 0;
        to    = 1'b1;
        nseen = 0;
        for (int i = 0; i < 20; i++) begin
            if (nseen < 16) begin
                seen[nseen] = probe;
                nseen++;
            end
            if (noise_cycles > 0) begin
                start = 1'b1;
                noise_cycles--;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            ncmp++;
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL invariant_busy_done: busy=%0b done=%0b both high", busy, done);
            end
            checks++;
            if (found && error) begin
                errors++;
                $display("FAIL invariant_found_error: found=%0b error=%0b both high", found, error);
            end
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, required within %0d", ncmp, W + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({probe, busy, done, found, result, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: probe=%0d busy=%0b done=%0b found=%0b result=%0d error=%0b, required all 0",
                     probe, busy, done, found, result, error);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_hit_first();
        int n;
        start_search(4'd7);
        checks++;
        if (probe !== 4'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_probe: probe=%0d busy=%0b, required probe=7 busy=1", probe, busy);
        end
        wait_done(n);
        checks++;
        if (n !== 1 || found !== 1'b1 || result !== 4'd7 || error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_first: cmps=%0d found=%0b result=%0d error=%0b busy=%0b, required 1/1/7/0/0",
                     n, found, result, error, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || found !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse_width: done=%0b found=%0b, required done=0 found=1", done, found);
        end
    endtask

    task automatic test_extremes();
        int n;
        logic [W-1:0] exp_hi [5];
        logic [W-1:0] exp_lo [4];
        exp_hi = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        exp_lo = '{4'd7, 4'd3, 4'd1, 4'd0};

        start_search(4'd15);
        wait_done(n);
        checks++;
        if (n !== 5 || found !== 1'b1 || result !== 4'd15) begin
            errors++;
            $display("FAIL target15: cmps=%0d found=%0b result=%0d, required 5/1/15", n, found, result);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen[i] !== exp_hi[i]) begin
                errors++;
                $display("FAIL target15_probe[%0d]: probe=%0d, required %0d", i, seen[i], exp_hi[i]);
            end
        end

        start_search(4'd0);
        wait_done(n);
        checks++;
        if (n !== 4 || found !== 1'b1 || result !== 4'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL target0: cmps=%0d found=%0b result=%0d error=%0b, required 4/1/0/0",
                     n, found, result, error);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen[i] !== exp_lo[i]) begin
                errors++;
                $display("FAIL target0_probe[%0d]: probe=%0d, required %0d", i, seen[i], exp_lo[i]);
            end
        end
    endtask

    task automatic test_sweep();
        int n;
        for (int t = 0; t < 16; t++) begin
            start_search(W'(t));
            wait_done(n);
            checks++;
            if (found !== 1'b1 || result !== W'(t) || error !== 1'b0 || n > W + 1) begin
                errors++;
                $display("FAIL sweep_t%0d: found=%0b result=%0d error=%0b cmps=%0d, required 1/%0d/0/<=5",
                         t, found, result, error, n, t);
            end
        end
    endtask

    task automatic test_invalid();
        start_search(4'd9);
        @(negedge clk);
        bad = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || found !== 1'b0 || error !== 1'b1 || result !== 4'd15 || probe !== 4'd11) begin
            errors++;
            $display("FAIL invalid_enc: done=%0b found=%0b error=%0b result=%0d probe=%0d, required 1/0/1/15/11",
                     done, found, error, result, probe);
        end
        bad = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_always_lt();
        int n;
        logic [W-1:0] exp_p [5];
        exp_p = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        mode_lt = 1'b1;
        start_search(4'd0);
        wait_done(n);
        checks++;
        if (n !== 5 || error !== 1'b1 || found !== 1'b0) begin
            errors++;
            $display("FAIL always_lt: cmps=%0d error=%0b found=%0b, required 5/1/0", n, error, found);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (seen[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL always_lt_probe[%0d]: probe=%0d, required %0d", i, seen[i], exp_p[i]);
            end
        end
        mode_lt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_during_search();
        int n;
        logic [W-1:0] exp_p [4];
        exp_p = '{4'd7, 4'd11, 4'd13, 4'd12};
        start_search(4'd12);
        noise_cycles = 2;
        wait_done(n);
        checks++;
        if (n !== 4 || found !== 1'b1 || result !== 4'd12) begin
            errors++;
            $display("FAIL start_ignored: cmps=%0d found=%0b result=%0d, required 4/1/12", n, found, result);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seen[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL start_ignored_probe[%0d]: probe=%0d, required %0d", i, seen[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_start_in_done();
        int n;
        mode_lt = 1'b1;
        start_search(4'd0);
        wait_done(n);
        mode_lt = 1'b0;
        target  = 4'd7;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || found !== 1'b0 || error !== 1'b0 || probe !== 4'd7) begin
            errors++;
            $display("FAIL start_in_done: busy=%0b done=%0b found=%0b error=%0b probe=%0d, required 1/0/0/0/7",
                     busy, done, found, error, probe);
        end
        wait_done(n);
        checks++;
        if (n !== 1 || found !== 1'b1 || result !== 4'd7) begin
            errors++;
            $display("FAIL start_in_done_result: cmps=%0d found=%0b result=%0d, required 1/1/7", n, found, result);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        start_search(4'd15);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || probe !== 4'd13) begin
            errors++;
            $display("FAIL pre_reset: busy=%0b probe=%0d, required 1/13", busy, probe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({probe, busy, done, found, result, error} !== '0) begin
            errors++;
            $display("FAIL reset_mid: probe=%0d busy=%0b done=%0b found=%0b result=%0d error=%0b, required all 0",
                     probe, busy, done, found, result, error);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: done=%0b busy=%0b, required 0/0", done, busy);
        end
        rst_n = 1'b1;
        start_search(4'd5);
        wait_done(n);
        checks++;
        if (n !== 3 || found !== 1'b1 || result !== 4'd5 || error !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: cmps=%0d found=%0b result=%0d error=%0b, required 3/1/5/0",
                     n, found, result, error);
        end
    endtask

    initial begin
        test_reset();
        test_hit_first();
        test_extremes();
        test_sweep();
        test_invalid();
        test_always_lt();
        test_start_during_search();
        test_start_in_done();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
